spi_reporter: RTL
=================

SPI_REPORTER -- requirements
Module: spi_reporter

Interface
REQ-001 SHALL have parameter first_byte, default 8'h00, frame header; bits [7:5] are forced into byte 0.
REQ-002 SHALL have parameter reporter_timeout, default 400, max cycles a byte may wait for acceptance.
REQ-003 SHALL have parameter frame_gap, default 0, min idle cycles between frames.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port report_valid  input  1  a 24-bit word is offered.
REQ-007 SHALL have port report_data  input  24  word to send; [23:16] go in byte 0, [15:8] in byte 1, [7:0] in byte 2.
REQ-008 SHALL have port report_ready  output  1  the word is accepted when this and report_valid are both high.
REQ-009 SHALL have port tx_byte  output  8  byte presented to the SPI byte engine.
REQ-010 SHALL have port tx_byte_valid  output  1  tx_byte is valid.
REQ-011 SHALL have port tx_byte_ready  input  1  the engine takes the byte when this and tx_byte_valid are both high.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last byte of a frame is taken.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL implement the FSM states IDLE, GAP, B0, B1, B2, plus CK when checksum is enabled.
REQ-015 SHALL drive report_ready high only in IDLE; it SHALL be combinational from state only and SHALL NOT depend on report_valid.
REQ-016 On acceptance in IDLE, SHALL register report_data and move to B0 on the next cycle.
REQ-017 In B0, SHALL drive tx_byte = {first_byte[7:5], data[20:16]}; data[23:21] are discarded.
REQ-018 In B1, SHALL drive tx_byte = data[15:8]; in B2, tx_byte = data[7:0].
REQ-019 SHALL hold tx_byte_valid high in states B0 through CK, with tx_byte stable until it is taken.
REQ-020 When a byte is taken, SHALL advance to the next byte state on the next cycle; there are no bubble cycles between bytes.
REQ-021 When the last byte is taken, SHALL pulse frame_done on the next cycle and enter GAP.
REQ-022 If frame_gap = 0, SHALL go directly to IDLE instead of GAP.
REQ-023 GAP SHALL count frame_gap cycles, then return to IDLE; report_ready stays low during GAP.
REQ-024 The wait counter SHALL be 16 bits, SHALL clear on every byte taken and on every entry to B0, and SHALL increment in byte states while tx_byte_ready is low.
REQ-025 When the wait counter equals reporter_timeout, SHALL on the next cycle drop tx_byte_valid, pulse timeout_err, discard the frame, and enter GAP; frame_done SHALL NOT pulse.
REQ-026 If tx_byte_ready rises in the same cycle the counter reaches reporter_timeout, the byte SHALL be taken and no timeout SHALL occur.
REQ-027 Throughput SHALL be one frame per (bytes + 1 + frame_gap) cycles with tx_byte_ready held high.

Reset
REQ-028 While rst_n is low at a clk edge, SHALL reset state to IDLE, counters to 0, and tx_byte, tx_byte_valid, frame_done and timeout_err to 0.
REQ-029 SHALL drive report_ready high on the first cycle after reset is released.
REQ-030 Reset asserted mid-frame SHALL abort the frame silently: no frame_done, no timeout_err, and no partial bytes after release.

Configuration
REQ-031 SHALL support the macro SPI_REPORTER_CHECKSUM_EN; when defined, a 4th byte in state CK = byte0 ^ byte1 ^ byte2, sent after B2 with the same handshake and timeout rules.
REQ-032 Without SPI_REPORTER_CHECKSUM_EN, the frame SHALL be exactly 3 bytes and CK SHALL be absent from the FSM.

Structure
REQ-033 SHALL place the state enum typedef and the header-mask constant 3'b111 in shared package spi_pkg, also to be used by spi_listener.
REQ-034 SHALL have no sub-module; the FSM, the wait counter and the gap counter are in a single module.

Verification
REQ-035 Bench SHALL cover: first_byte=8'hA0, report_data=24'h1F2233, ready always high -> bytes A0? no: 0xBF, 0x22, 0x33 on consecutive cycles, then frame_done one cycle later.
REQ-036 Bench SHALL cover: tx_byte_ready low for 400 cycles during B1 -> timeout_err pulse, valid drops, next frame starts again at B0.
REQ-037 Bench SHALL cover: tx_byte_ready rises exactly at wait count 400 -> byte taken, no timeout_err.
REQ-038 Bench SHALL cover: frame_gap=5, back-to-back report_valid -> 5 idle cycles, ready low, then ready high.
REQ-039 Bench SHALL cover: rst_n low during B1 for one cycle -> tx_byte_valid=0 after the edge, report_ready=1 after release, no pulses.
REQ-040 Bench SHALL cover: with SPI_REPORTER_CHECKSUM_EN, data 24'h010203, first_byte 8'h00 -> bytes 01, 02, 03, 00.

Source files
------------

// File: rtl/spi_pkg.sv
// Definitions shared by spi_reporter and spi_listener: FSM state encoding and header mask.
// Defining SPI_REPORTER_CHECKSUM_EN adds the CK state for the trailing checksum byte.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        B0,
        B1,
        B2
`ifdef SPI_REPORTER_CHECKSUM_EN
        , CK
`endif
    } state_t;

    // Bits of first_byte that overwrite the top of byte 0.
    localparam logic [2:0] HDR_MASK = 3'b111;

    function automatic logic [7:0] checksum3(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/spi_reporter.sv
// Serialises 24-bit report words into 3-byte frames (4 with SPI_REPORTER_CHECKSUM_EN)
// for an SPI byte engine, with a per-byte acceptance timeout and an optional inter-frame gap.
module spi_reporter
    import spi_pkg::*;
#(
    parameter logic [7:0]  first_byte       = 8'h00,
    parameter int unsigned reporter_timeout = 400,
    parameter int unsigned frame_gap        = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        report_valid,
    input  logic [23:0] report_data,
    output logic        report_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(reporter_timeout);
    localparam logic [15:0] GAP_LAST    = (frame_gap == 0) ? 16'd0 : 16'(frame_gap - 1);
    localparam state_t      END_STATE   = (frame_gap == 0) ? IDLE : GAP;

    state_t      state_q, state_d;
    logic [20:0] data_q, data_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] gap_q, gap_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  head_in;

    // The top three report bits are replaced by the frame header and never stored.
    logic [2:0]  unused_report_bits;
    assign unused_report_bits = report_data[23:21];

    assign head_in = {first_byte[7:5] & HDR_MASK, report_data[20:16]};

`ifdef SPI_REPORTER_CHECKSUM_EN
    logic [7:0] head_q;
    logic [7:0] ck_byte;
    assign head_q  = {first_byte[7:5] & HDR_MASK, data_q[20:16]};
    assign ck_byte = checksum3(head_q, data_q[15:8], data_q[7:0]);
`endif

    assign report_ready  = (state_q == IDLE);
    assign tx_byte       = tx_byte_q;
    assign tx_byte_valid = tx_valid_q;
    assign frame_done    = done_q;
    assign timeout_err   = tmo_q;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        wait_d     = wait_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (report_valid) begin
                    data_d     = report_data[20:0];
                    tx_byte_d  = head_in;
                    tx_valid_d = 1'b1;
                    wait_d     = '0;
                    state_d    = B0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                // A byte taken on the very cycle the count hits the limit wins over the timeout.
                if (tx_byte_ready) begin
                    wait_d = '0;
                    unique case (state_q)
                        B0: begin
                            state_d   = B1;
                            tx_byte_d = data_q[15:8];
                        end
                        B1: begin
                            state_d   = B2;
                            tx_byte_d = data_q[7:0];
                        end
`ifdef SPI_REPORTER_CHECKSUM_EN
                        B2: begin
                            state_d   = CK;
                            tx_byte_d = ck_byte;
                        end
`endif
                        default: begin
                            state_d    = END_STATE;
                            tx_byte_d  = '0;
                            tx_valid_d = 1'b0;
                            gap_d      = '0;
                            done_d     = 1'b1;
                        end
                    endcase
                end else if (wait_q == TIMEOUT_CNT) begin
                    state_d    = END_STATE;
                    tx_byte_d  = '0;
                    tx_valid_d = 1'b0;
                    wait_d     = '0;
                    gap_d      = '0;
                    tmo_d      = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            wait_q     <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule
